// File: rtl/time_set_controller_pkg.sv
// Shared types and constants for the time-set controller.
// Field wrap helpers keep edit values inside their legal range.
package time_set_controller_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_HRS,
    ST_SET_MIN,
    ST_SET_SEC,
    ST_COMMIT
  } state_e;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HRS  = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  localparam logic [4:0] HRS_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] SEC_MAX = 6'd59;

  function automatic logic [4:0] step_hrs(
    input logic [4:0] v,
    input logic       inc,
    input logic       dec
  );
    step_hrs = v;
    if (inc && !dec)
      step_hrs = (v == HRS_MAX) ? 5'd0 : v + 5'd1;
    else if (dec && !inc)
      step_hrs = (v == 5'd0) ? HRS_MAX : v - 5'd1;
  endfunction

  function automatic logic [5:0] step_ms(
    input logic [5:0] v,
    input logic [5:0] vmax,
    input logic       inc,
    input logic       dec
  );
    step_ms = v;
    if (inc && !dec)
      step_ms = (v == vmax) ? 6'd0 : v + 6'd1;
    else if (dec && !inc)
      step_ms = (v == 6'd0) ? vmax : v - 6'd1;
  endfunction

endpackage

// File: rtl/time_set_controller_tick_prescaler.sv
// Modulo-N cycle counter; tick flags the cycle whose edge wraps it.
// Clear has priority over enable and suppresses the tick.
module tick_prescaler #(
  parameter int N = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = i_en && !i_clr && (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
  end

endmodule

// File: rtl/time_set_controller.sv
// Clock time-set controller: second prescaler plus edit FSM that
// captures, adjusts and loads hours/minutes/seconds.
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int CLKS_PER_SEC = 100000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] mode,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hrs,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       sec_tick,
  output logic       load,
  output logic [4:0] ld_hrs,
  output logic [5:0] ld_min,
  output logic [5:0] ld_sec,
  output logic [1:0] edit_field,
  output logic       blink
);

  state_e     r_state;
  logic [4:0] r_hrs;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic       r_sec_tick;
  logic       r_load;
  logic       r_blink;
  logic [1:0] r_field;

  logic       w_active;
  logic       w_in_set;
  logic       w_adj;
  logic       w_sec_wrap;
  logic       w_blink_wrap;
  logic [4:0] w_hrs_nxt;
  logic [5:0] w_min_nxt;
  logic [5:0] w_sec_nxt;

  assign w_active = enable && (mode == 3'd0);
  assign w_in_set = (r_state == ST_SET_HRS) ||
                    (r_state == ST_SET_MIN) ||
                    (r_state == ST_SET_SEC);
  assign w_adj    = btn_inc || btn_dec;

  assign w_hrs_nxt = step_hrs(r_hrs, btn_inc, btn_dec);
  assign w_min_nxt = step_ms(r_min, MIN_MAX, btn_inc, btn_dec);
  assign w_sec_nxt = step_ms(r_sec, SEC_MAX, btn_inc, btn_dec);

  // COMMIT starts the new second at count 0, so it counts as cycle 1.
  tick_prescaler #(.N(CLKS_PER_SEC)) u_sec_pre (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_in_set),
    .i_en   (w_active && !w_in_set),
    .o_tick (w_sec_wrap)
  );

  tick_prescaler #(.N(BLINK_CYCLES)) u_blink_pre (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (!w_in_set || w_adj),
    .i_en   (w_in_set),
    .o_tick (w_blink_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_hrs      <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      r_sec_tick <= 1'b0;
      r_load     <= 1'b0;
      r_blink    <= 1'b0;
      r_field    <= FLD_NONE;
    end else begin
      r_load     <= 1'b0;
      r_sec_tick <= 1'b0;
      unique case (r_state)
        ST_RUN: begin
          r_blink <= 1'b0;
          r_field <= FLD_NONE;
          if (w_active && btn_set) begin
            r_state <= ST_SET_HRS;
            r_field <= FLD_HRS;
            r_hrs   <= cur_hrs;
            r_min   <= cur_min;
            r_sec   <= cur_sec;
          end else begin
            r_sec_tick <= w_sec_wrap;
          end
        end
        ST_SET_HRS, ST_SET_MIN, ST_SET_SEC: begin
          if (!w_active) begin
            r_state <= ST_RUN;
            r_field <= FLD_NONE;
            r_blink <= 1'b0;
          end else begin
            if (r_state == ST_SET_HRS) r_hrs <= w_hrs_nxt;
            if (r_state == ST_SET_MIN) r_min <= w_min_nxt;
            if (r_state == ST_SET_SEC) r_sec <= w_sec_nxt;
            if (w_adj)
              r_blink <= 1'b0;
            else if (w_blink_wrap)
              r_blink <= !r_blink;
            if (btn_set) begin
              unique case (r_state)
                ST_SET_HRS: begin
                  r_state <= ST_SET_MIN;
                  r_field <= FLD_MIN;
                end
                ST_SET_MIN: begin
                  r_state <= ST_SET_SEC;
                  r_field <= FLD_SEC;
                end
                default: begin
                  r_state <= ST_COMMIT;
                  r_field <= FLD_NONE;
                  r_load  <= 1'b1;
                  r_blink <= 1'b0;
                end
              endcase
            end
          end
        end
        ST_COMMIT: begin
          r_state <= ST_RUN;
          r_field <= FLD_NONE;
          r_blink <= 1'b0;
        end
        default: begin
          r_state <= ST_RUN;
          r_field <= FLD_NONE;
          r_blink <= 1'b0;
        end
      endcase
    end
  end

  assign sec_tick   = r_sec_tick;
  assign load       = r_load;
  assign ld_hrs     = r_hrs;
  assign ld_min     = r_min;
  assign ld_sec     = r_sec;
  assign edit_field = r_field;
  assign blink      = r_blink;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with hand-computed
// expectations (CLKS_PER_SEC=10, BLINK_CYCLES=4).
module tb_time_set_controller;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] mode;
  logic       btn_set;
  logic       btn_inc;
  logic       btn_dec;
  logic [4:0] cur_hrs;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       sec_tick;
  logic       load;
  logic [4:0] ld_hrs;
  logic [5:0] ld_min;
  logic [5:0] ld_sec;
  logic [1:0] edit_field;
  logic       blink;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt;

  time_set_controller #(
    .CLKS_PER_SEC (10),
    .BLINK_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .btn_set    (btn_set),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .cur_hrs    (cur_hrs),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .sec_tick   (sec_tick),
    .load       (load),
    .ld_hrs     (ld_hrs),
    .ld_min     (ld_min),
    .ld_sec     (ld_sec),
    .edit_field (edit_field),
    .blink      (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic i, input logic d);
    btn_set = s;
    btn_inc = i;
    btn_dec = d;
    step();
    btn_set = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    mode = 3'd0;
    btn_set = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    cur_hrs = 5'd12;
    cur_min = 6'd34;
    cur_sec = 6'd56;
    repeat (3) step();
    chk("rst_tick", sec_tick, 0);
    chk("rst_load", load, 0);
    chk("rst_field", edit_field, 0);
    chk("rst_blink", blink, 0);
    chk("rst_ld", {ld_hrs, ld_min, ld_sec}, 0);
    rst = 1'b0;

    // free-running seconds
    for (int k = 1; k <= 35; k++) begin
      step();
      chk($sformatf("tick_c%0d", k), sec_tick, 32'(k % 10 == 0));
    end

    // full edit sequence 12:34:56 -> 00:59:00
    press(1, 0, 0);
    chk("e_field1", edit_field, 1);
    chk("e_cap", {ld_hrs, ld_min, ld_sec}, {5'd12, 6'd34, 6'd56});
    chk("e_tick0", sec_tick, 0);
    repeat (12) press(0, 1, 0);
    chk("e_hrs", ld_hrs, 0);
    press(1, 0, 0);
    chk("e_field2", edit_field, 2);
    repeat (35) press(0, 0, 1);
    chk("e_min", ld_min, 59);
    chk("e_tick1", sec_tick, 0);
    press(1, 0, 0);
    chk("e_field3", edit_field, 3);
    repeat (4) press(0, 1, 0);
    chk("e_sec", ld_sec, 0);
    press(1, 0, 0);
    chk("c_load", load, 1);
    chk("c_field0", edit_field, 0);
    chk("c_ld", {ld_hrs, ld_min, ld_sec}, {5'd0, 6'd59, 6'd0});
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      cnt += int'(load);
      chk($sformatf("post_tick_c%0d", k), sec_tick, 32'(k == 10));
    end
    chk("c_one_load", cnt, 0);

    // blink cadence and wrap boundaries
    cur_hrs = 5'd23;
    cur_min = 6'd0;
    cur_sec = 6'd30;
    press(1, 0, 0);
    chk("b_c0", blink, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("b_c%0d", k), blink, 32'((k / 4) % 2));
    end
    press(0, 1, 0);
    chk("b_inc_clr", blink, 0);
    chk("w_hrs_23_0", ld_hrs, 0);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("b_re_c%0d", j), blink, 32'(j == 4));
    end
    press(0, 0, 1);
    chk("w_hrs_0_23", ld_hrs, 23);
    chk("b_dec_clr", blink, 0);
    press(0, 1, 1);
    chk("w_incdec", ld_hrs, 23);
    press(1, 0, 0);
    chk("w_field2", edit_field, 2);
    press(0, 0, 1);
    chk("w_min_0_59", ld_min, 59);
    press(0, 1, 0);
    chk("w_min_59_0", ld_min, 0);

    // leave active while in SET_MIN
    mode = 3'd1;
    step();
    chk("a_field0", edit_field, 0);
    chk("a_load", load, 0);
    chk("a_blink", blink, 0);
    cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      cnt += int'(sec_tick) + int'(load);
    end
    chk("a_quiet", cnt, 0);
    press(1, 0, 0);
    chk("a_set_ign", edit_field, 0);
    press(0, 1, 0);
    chk("a_inc_ign", ld_hrs, 23);
    mode = 3'd0;

    // asynchronous reset in SET_SEC
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    chk("r_field3", edit_field, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("r_tick", sec_tick, 0);
    chk("r_load", load, 0);
    chk("r_field", edit_field, 0);
    chk("r_blink", blink, 0);
    chk("r_ld", {ld_hrs, ld_min, ld_sec}, 0);
    step();
    rst = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      cnt += int'(load) * 100 + int'(sec_tick);
    end
    chk("r_noload_ticks", cnt, 3);
    chk("r_field_end", edit_field, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter CLKS_PER_SEC, default 100000000, clk cycles per 1 s tick.
REQ-002 SHALL have parameter BLINK_CYCLES, default 25000000, clk cycles per blink half-period.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; clk  in  1  system clock, all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  clock on/off switch.
REQ-006 mode  in  3  operating mode; timekeeping and editing only when mode==0.
REQ-007 btn_set  in  1  single-cycle debounced pulse; enter edit or advance field.
REQ-008 btn_inc  in  1  single-cycle debounced pulse; increment edited field.
REQ-009 btn_dec  in  1  single-cycle debounced pulse; decrement edited field.
REQ-010 cur_hrs  in  5  current hours from the timekeeping datapath (0-23).
REQ-011 cur_min  in  6  current minutes (0-59).
REQ-012 cur_sec  in  6  current seconds (0-59).
REQ-013 sec_tick  out  1  one-cycle pulse per elapsed second while running.
REQ-014 load  out  1  one-cycle strobe: datapath takes ld_hrs/ld_min/ld_sec.
REQ-015 ld_hrs  out  5, ld_min  out  6, ld_sec  out  6  edit values; valid whenever load==1, show live edit values otherwise.
REQ-016 edit_field  out  2  0=none, 1=hours, 2=minutes, 3=seconds.
REQ-017 blink  out  1  display blank phase for the edited field.

Function
REQ-018 SHALL implement FSM states RUN, SET_HRS, SET_MIN, SET_SEC, COMMIT; active = enable==1 && mode==0.
REQ-019 RUN: prescaler counts 0..CLKS_PER_SEC-1 while active; sec_tick=1 in the cycle the count wraps to 0; prescaler holds its value when not active.
REQ-020 RUN + btn_set + active -> SET_HRS; same edge captures cur_hrs/min/sec into edit registers.
REQ-021 SET_HRS -btn_set-> SET_MIN -btn_set-> SET_SEC -btn_set-> COMMIT -> RUN (unconditional, 1 cycle).
REQ-022 COMMIT: load=1 for exactly one cycle; prescaler cleared to 0 so the first post-load second is a full CLKS_PER_SEC cycles.
REQ-023 In SET_* states sec_tick=0, prescaler held at 0, load=0.
REQ-024 btn_inc alone: field+1, wraps hours 23->0, minutes/seconds 59->0.
REQ-025 btn_dec alone: field-1, wraps hours 0->23, minutes/seconds 0->59.
REQ-026 btn_inc and btn_dec in the same cycle: no change.
REQ-027 btn_set together with inc/dec: field change applied to the current field and the state advances on the same edge.
REQ-028 Edit values never leave range; arithmetic performed at field width with explicit wrap compare, no modulo.
REQ-029 Active deasserts in any SET_* state: next state RUN, no load, edits discarded.
REQ-030 inc/dec ignored in RUN and COMMIT; btn_set ignored in COMMIT and when not active.
REQ-031 edit_field = 1/2/3 in SET_HRS/SET_MIN/SET_SEC, 0 otherwise.
REQ-032 blink toggles every BLINK_CYCLES clk cycles in SET_* states; forced 0 and its counter cleared on entry to RUN; inc/dec clear blink and its counter, keeping the field visible.

Reset
REQ-033 rst SHALL force state RUN, prescaler 0, blink counter 0, edit registers 0, sec_tick 0, load 0, edit_field 0, blink 0, ld_* 0.
REQ-034 rst asserted mid-edit or during COMMIT SHALL suppress load; no partial load is issued.

Structure
REQ-035 Shared package SHALL hold: state encoding, field-code constants (0-3), HRS_MAX=23, MIN_MAX=59, SEC_MAX=59.
REQ-036 One sub-module, tick_prescaler (parameterised count, clear, enable, tick out), SHALL be instantiated twice: second tick and blink.

Verification (CLKS_PER_SEC=10, BLINK_CYCLES=4)
REQ-037 Active, no buttons for 35 cycles after reset release -> sec_tick pulses at cycles 10, 20, 30 only.
REQ-038 cur=12:34:56; set, inc x12, set, dec x35, set, inc x4, set -> one load pulse with ld=00:59:00, edit_field sequence 1,2,3,0.
REQ-039 Hours 23 + inc -> 0; minutes 0 + dec -> 59; inc+dec same cycle -> value unchanged.
REQ-040 In SET_MIN, mode set to 1 -> next cycle state RUN, edit_field 0, no load, no sec_tick while mode!=0.
REQ-041 rst asserted in SET_SEC -> all outputs 0 immediately (asynchronous); after release no load ever issued.
REQ-042 After COMMIT -> next sec_tick exactly 10 cycles after load; blink toggles every 4 cycles during SET_*, 0 in RUN.
